phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Produces the five one-hot per-instruction phase strobes
//               (IF, ID, ALU, MEM, RB_BR) from a single system clock.
//               Handles halt (branch_opcode == 3'b000), the interrupt wait
//               state, and MEM-phase stretching on mem_ready.
//               Define PHASE_SEQ_PERF_EN to build in the retired-instruction
//               and RUN-cycle performance counters. When it is undefined,
//               both counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int CNT_W      = 32,
    parameter int AUTO_START = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       branch_opcode,
    input  logic             interrupt,
    input  logic             mem_ready,
    input  logic             int_ack,
    output logic             IF_clk,
    output logic             ID_clk,
    output logic             ALU_clk,
    output logic             MEM_clk,
    output logic             RB_BR_clk,
    output logic             running,
    output logic             halted,
    output logic             int_pending,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HALTED   = 2'd2,
        ST_INT_WAIT = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        PH_IF    = 3'd0,
        PH_ID    = 3'd1,
        PH_ALU   = 3'd2,
        PH_MEM   = 3'd3,
        PH_RB_BR = 3'd4
    } phase_e;

    state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic   halt_q;
    logic   int_q;
    // One-shot kick that replaces start on the first cycle after reset when
    // AUTO_START is set. The first IF strobe is still a real registered edge.
    logic   auto_go_q;

    // Next-state and next-phase selection
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start || auto_go_q) begin
                    state_d = ST_RUN;
                    phase_d = PH_IF;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    phase_d = PH_IF;
                end
            end
            ST_INT_WAIT: begin
                if (int_ack) begin
                    state_d = ST_RUN;
                    phase_d = PH_IF;
                end
            end
            ST_RUN: begin
                case (phase_q)
                    PH_IF:  phase_d = PH_ID;
                    PH_ID:  phase_d = PH_ALU;
                    PH_ALU: phase_d = PH_MEM;
                    PH_MEM: begin
                        if (mem_ready) begin
                            phase_d = PH_RB_BR;
                        end
                    end
                    PH_RB_BR: begin
                        // Halt wins over a pending interrupt.
                        phase_d = PH_IF;
                        if (halt_q) begin
                            state_d = ST_HALTED;
                        end else if (int_q) begin
                            state_d = ST_INT_WAIT;
                        end
                    end
                    default: phase_d = PH_IF;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_IF;
            end
        endcase
    end

    // State, sampled flags and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_IF;
            halt_q      <= 1'b0;
            int_q       <= 1'b0;
            auto_go_q   <= (AUTO_START != 0);
            IF_clk      <= 1'b0;
            ID_clk      <= 1'b0;
            ALU_clk     <= 1'b0;
            MEM_clk     <= 1'b0;
            RB_BR_clk   <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            auto_go_q <= 1'b0;

            // The interrupt flag is captured only during the ALU phase.
            if (state_q == ST_RUN && phase_q == PH_ALU) begin
                int_q <= interrupt;
            end
            // Halt is captured only on the MEM cycle that actually advances.
            if (state_q == ST_RUN && phase_q == PH_MEM && mem_ready) begin
                halt_q <= (branch_opcode == 3'b000);
            end
            // Both flags are dropped as a fresh instruction begins.
            if (state_d == ST_RUN && phase_d == PH_IF) begin
                halt_q <= 1'b0;
                int_q  <= 1'b0;
            end

            IF_clk      <= (state_d == ST_RUN) && (phase_d == PH_IF);
            ID_clk      <= (state_d == ST_RUN) && (phase_d == PH_ID);
            ALU_clk     <= (state_d == ST_RUN) && (phase_d == PH_ALU);
            MEM_clk     <= (state_d == ST_RUN) && (phase_d == PH_MEM);
            RB_BR_clk   <= (state_d == ST_RUN) && (phase_d == PH_RB_BR);
            running     <= (state_d == ST_RUN);
            halted      <= (state_d == ST_HALTED);
            int_pending <= (state_d == ST_INT_WAIT);
        end
    end

`ifdef PHASE_SEQ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] cycle_q;

    // Free-running wrap-around counters of RUN cycles and completed RB_BR phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (state_q == ST_RUN) begin
                cycle_q <= cycle_q + CNT_ONE;
            end
            if (state_q == ST_RUN && phase_q == PH_RB_BR) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Directed self-checking bench for phase_sequencer. A second
//               instance with CNT_W = 4 shares the stimulus so that counter
//               wrap can be observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

`ifdef PHASE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_IF   = 5'b10000;
    localparam logic [4:0] S_ID   = 5'b01000;
    localparam logic [4:0] S_ALU  = 5'b00100;
    localparam logic [4:0] S_MEM  = 5'b00010;
    localparam logic [4:0] S_RB   = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  branch_opcode;
    logic        interrupt;
    logic        mem_ready;
    logic        int_ack;

    logic        if_c, id_c, alu_c, mem_c, rb_c;
    logic        running, halted, int_pending;
    logic [31:0] retired_cnt, cycle_cnt;

    logic        if4, id4, alu4, mem4, rb4;
    logic        running4, halted4, int_pending4;
    logic [3:0]  retired4, cycle4;

    logic [4:0]  strobes, strobes4;
    assign strobes  = {if_c, id_c, alu_c, mem_c, rb_c};
    assign strobes4 = {if4, id4, alu4, mem4, rb4};

    int compared   = 0;
    int mismatched = 0;
    int exp_cyc    = 0;
    int exp_ret    = 0;

    phase_sequencer #(.CNT_W(32), .AUTO_START(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .branch_opcode(branch_opcode),
        .interrupt(interrupt), .mem_ready(mem_ready), .int_ack(int_ack),
        .IF_clk(if_c), .ID_clk(id_c), .ALU_clk(alu_c), .MEM_clk(mem_c), .RB_BR_clk(rb_c),
        .running(running), .halted(halted), .int_pending(int_pending),
        .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
    );

    phase_sequencer #(.CNT_W(4), .AUTO_START(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .branch_opcode(branch_opcode),
        .interrupt(interrupt), .mem_ready(mem_ready), .int_ack(int_ack),
        .IF_clk(if4), .ID_clk(id4), .ALU_clk(alu4), .MEM_clk(mem4), .RB_BR_clk(rb4),
        .running(running4), .halted(halted4), .int_pending(int_pending4),
        .retired_cnt(retired4), .cycle_cnt(cycle4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_strobes(input string tag, input logic [4:0] expv);
        check(tag, {27'd0, strobes}, {27'd0, expv});
        check({tag, "_w4"}, {27'd0, strobes4}, {27'd0, expv});
    endtask

    task automatic chk_counters(input string tag);
        check({tag, "_retired"}, retired_cnt, PERF ? exp_ret : 0);
        check({tag, "_cycles"}, cycle_cnt, PERF ? exp_cyc : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick out of a cycle that the DUT spends in RUN.
    task automatic tick_run();
        tick();
        exp_cyc++;
    endtask

    // Precondition: the IF strobe is showing. Walks one instruction, driving
    // out-of-window noise on interrupt/mem_ready/branch_opcode, and returns
    // just after the edge that ends RB_BR.
    task automatic do_instr(input int stalls, input bit hlt, input bit irq);
        logic [2:0] fin;
        fin = hlt ? 3'b000 : 3'b011;
        chk_strobes("ph_IF", S_IF);
        interrupt = 1'b1; mem_ready = 1'b0; branch_opcode = 3'b000;
        tick_run();
        chk_strobes("ph_ID", S_ID);
        tick_run();
        chk_strobes("ph_ALU", S_ALU);
        interrupt = irq;
        tick_run();
        chk_strobes("ph_MEM", S_MEM);
        interrupt = 1'b1;
        mem_ready = (stalls == 0);
        branch_opcode = (stalls == 0) ? fin : 3'b000;
        for (int s = 0; s < stalls; s++) begin
            tick_run();
            chk_strobes("ph_MEM_stall", S_MEM);
            if (s == stalls - 1) begin
                mem_ready = 1'b1;
                branch_opcode = fin;
            end
        end
        tick_run();
        chk_strobes("ph_RB", S_RB);
        interrupt = 1'b1; mem_ready = 1'b0; branch_opcode = 3'b000;
        tick_run();
        exp_ret++;
        interrupt = 1'b0; mem_ready = 1'b1; branch_opcode = 3'b011;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; branch_opcode = 3'b011;
        interrupt = 1'b0; mem_ready = 1'b1; int_ack = 1'b0;
        repeat (3) tick();

        // Reset state
        chk_strobes("rst_strobes", S_NONE);
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_int_pending", {31'd0, int_pending}, 32'd0);
        check("rst_running_w4", {31'd0, running4}, 32'd0);
        check("rst_int_pending_w4", {31'd0, int_pending4}, 32'd0);
        chk_counters("rst");

        // Idle without start
        rst_n = 1'b1;
        tick();
        chk_strobes("idle_strobes", S_NONE);
        check("idle_running", {31'd0, running}, 32'd0);

        // Start; start stays high during instruction 1 and must be ignored
        start = 1'b1;
        tick();
        check("start_running", {31'd0, running}, 32'd1);
        do_instr(0, 1'b0, 1'b0);
        start = 1'b0;

        // Instruction 2 takes an interrupt
        do_instr(0, 1'b0, 1'b1);
        chk_strobes("intw_strobes", S_NONE);
        check("intw_pending", {31'd0, int_pending}, 32'd1);
        check("intw_running", {31'd0, running}, 32'd0);
        start = 1'b1;
        repeat (4) begin
            tick();
            check("intw_hold_pending", {31'd0, int_pending}, 32'd1);
            chk_strobes("intw_hold_strobes", S_NONE);
        end
        start = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("ack_pending", {31'd0, int_pending}, 32'd0);
        check("ack_running", {31'd0, running}, 32'd1);

        // Instruction 3 halts
        do_instr(0, 1'b1, 1'b0);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_running", {31'd0, running}, 32'd0);
        chk_strobes("halt_strobes", S_NONE);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("halt_ack_ignored", {31'd0, halted}, 32'd1);
        chk_strobes("halt_no_if", S_NONE);
        tick();
        chk_strobes("halt_no_if2", S_NONE);
        check("halt_cnt_ret_val", retired_cnt, PERF ? 32'd3 : 32'd0);
        chk_counters("halt");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_halted", {31'd0, halted}, 32'd0);

        // MEM stall: 3 extra MEM cycles, 8-cycle instruction
        do_instr(3, 1'b0, 1'b0);
        check("stall_cycles_val", cycle_cnt, PERF ? 32'd23 : 32'd0);
        chk_counters("stall");

        // Halt and interrupt in the same instruction
        do_instr(0, 1'b1, 1'b1);
        check("hi_halted", {31'd0, halted}, 32'd1);
        check("hi_pending", {31'd0, int_pending}, 32'd0);
        tick();
        check("hi_pending2", {31'd0, int_pending}, 32'd0);

        // Reset in the middle of an instruction
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_run();
        tick_run();
        chk_strobes("pre_rst_alu", S_ALU);
        rst_n = 1'b0;
        #1;
        exp_cyc = 0;
        exp_ret = 0;
        chk_strobes("async_rst_strobes", S_NONE);
        check("async_rst_running", {31'd0, running}, 32'd0);
        chk_counters("async_rst");
        #4;
        rst_n = 1'b1;
        tick();
        chk_strobes("post_rst_idle", S_NONE);
        tick();
        chk_strobes("post_rst_idle2", S_NONE);
        check("post_rst_running", {31'd0, running}, 32'd0);

        // 17 back-to-back instructions; the 4-bit counter wraps to 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            do_instr(0, 1'b0, 1'b0);
        end
        check("wrap_retired_w4", {28'd0, retired4}, PERF ? 32'd1 : 32'd0);
        check("wrap_cycles_w4", {28'd0, cycle4}, PERF ? 32'd5 : 32'd0);
        check("b2b_cycles_val", cycle_cnt, PERF ? 32'd85 : 32'd0);
        chk_counters("b2b");
        do_instr(0, 1'b1, 1'b0);
        check("final_halted", {31'd0, halted}, 32'd1);
        check("final_halted_w4", {31'd0, halted4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
